// File: rtl/lin_pkg.sv
// lin_pkg: shared definitions for the LIN byte receiver (and the lin_tx
// block that will follow it).
//   lin_state_e  : receive FSM states
//   lin_par_e    : parity-mode encoding for the PARITY_ODD parameter
//   VOTE_SAMPLES : samples per bit fed to the majority vote
//   smp_pt()     : oversample index of vote sample k, centred on the bit
package lin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK,
    ST_WAIT_HIGH
  } lin_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } lin_par_e;

  localparam int VOTE_SAMPLES = 3;

  // Samples sit at OSR/2-1, OSR/2, OSR/2+1 within the bit.
  function automatic int smp_pt(input int osr, input int k);
    return osr / 2 - 1 + k;
  endfunction

endpackage

// File: rtl/lin_os_tick.sv
// lin_os_tick: oversample tick generator and per-bit oversample counter.
//   clk, rst_n : clock, async active-low reset
//   baud_div   : clk cycles per oversample tick (0 behaves as 1)
//   align      : reload divider and clear oversample count (start edge)
//   smp_stb    : one-cycle strobes on the ticks of the vote samples
module lin_os_tick
  import lin_pkg::*;
#(
  parameter int OSR = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             baud_div,
  input  logic                    align,
  output logic [VOTE_SAMPLES-1:0] smp_stb
);

  localparam int OSW = $clog2(OSR);

  logic [15:0]    div_q, div_d, reload;
  logic [OSW-1:0] os_q, os_d;
  logic           tick;

  always_comb begin
    reload = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    tick   = (div_q == 16'd0);
    div_d  = tick ? reload : div_q - 16'd1;
    os_d   = os_q;
    if (tick) os_d = (os_q == OSW'(OSR - 1)) ? '0 : os_q + 1'b1;
    // Restart bit phase from the start edge.
    if (align) begin
      div_d = reload;
      os_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      os_q  <= '0;
    end else begin
      div_q <= div_d;
      os_q  <= os_d;
    end
  end

  for (genvar k = 0; k < VOTE_SAMPLES; k++) begin : g_stb
    assign smp_stb[k] = tick & (os_q == OSW'(smp_pt(OSR, k)));
  end

endmodule

// File: rtl/lin_rx_os.sv
// lin_rx_os: LIN/UART byte receiver with its own oversampled bit timing,
// 3-sample majority vote, optional parity, stop check, break detection and
// a valid/ready output register with overrun reporting.
//   lin_rx_rtl            : raw pin (async, recessive 1)
//   baud_div, rx_en       : tick divider, receiver enable
//   rx_data_vld/rdy/data  : output handshake and character
//   rx_stop_err/par_err   : qualifiers of rx_data_vld
//   rx_overrun, rx_break  : one-cycle event pulses
//   rx_busy               : FSM not idle
module lin_rx_os
  import lin_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OSR        = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int BREAK_BITS = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       baud_div,
  input  logic              rx_en,
  input  logic              lin_rx_rtl,
  output logic              rx_data_vld,
  input  logic              rx_data_rdy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_stop_err,
  output logic              rx_par_err,
  output logic              rx_overrun,
  output logic              rx_break,
  output logic              rx_busy
);

  lin_state_e              state_q, state_d;
  logic                    sync1_q, sync1_d, sync2_q, sync2_d, line_q, line_d;
  logic                    s0_q, s0_d, s1_q, s1_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic                    par_err_q, par_err_d, par_bit_q, par_bit_d;
  logic [7:0]              brk_cnt_q, brk_cnt_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    vld_q, vld_d, se_q, se_d, pe_q, pe_d;
  logic                    ovr_q, ovr_d, brk_q, brk_d;
  logic [VOTE_SAMPLES-1:0] smp_stb;
  logic                    fall, vote, bit_dec, align, acc;
  logic                    ld, ld_se, brk_hit;
  logic [DATA_W-1:0]       ld_data;

  lin_os_tick #(.OSR(OSR)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_div (baud_div),
    .align    (align),
    .smp_stb  (smp_stb)
  );

  // Synchroniser, edge detect and vote sample capture.
  always_comb begin
    sync1_d = lin_rx_rtl;
    sync2_d = sync1_q;
    line_d  = sync2_q;
    fall    = line_q & ~sync2_q;
    s0_d    = smp_stb[0] ? sync2_q : s0_q;
    s1_d    = smp_stb[1] ? sync2_q : s1_q;
    bit_dec = smp_stb[2];
    vote    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    par_bit_d = par_bit_q;
    brk_cnt_d = brk_cnt_q;
    align     = 1'b0;
    ld        = 1'b0;
    ld_data   = shift_q;
    ld_se     = 1'b0;
    brk_hit   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (rx_en && fall) begin
        state_d = ST_START;
        align   = 1'b1;
      end
      ST_START: if (bit_dec) begin
        if (vote) state_d = ST_IDLE;
        else begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          par_bit_d = 1'b0;
        end
      end
      ST_DATA: if (bit_dec) begin
        shift_d   = {vote, shift_q[DATA_W-1:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_W - 1))
          state_d = PARITY_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_dec) begin
        par_bit_d = vote;
        par_err_d = (^shift_q) ^ vote ^ (lin_par_e'(PARITY_ODD) == PAR_ODD);
        state_d   = ST_STOP;
      end
      ST_STOP: if (bit_dec) begin
        if (vote) begin
          ld      = 1'b1;
          state_d = ST_IDLE;
        end else if (shift_q == '0 && !(PARITY_EN && par_bit_q)) begin
          // Everything dominant so far: start + data + parity + stop.
          brk_cnt_d = 8'(2 + DATA_W + int'(PARITY_EN));
          state_d   = ST_BREAK;
        end else begin
          ld      = 1'b1;
          ld_se   = 1'b1;
          state_d = ST_WAIT_HIGH;
        end
      end
      ST_BREAK: if (bit_dec) begin
        if (!vote) begin
          brk_cnt_d = brk_cnt_q + 8'd1;
          if (brk_cnt_q + 8'd1 >= 8'(BREAK_BITS)) begin
            brk_hit = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          // Too short for a break: report as a zero char with framing error.
          ld      = 1'b1;
          ld_data = '0;
          ld_se   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_HIGH: if (sync2_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!rx_en) begin
      state_d = ST_IDLE;
      ld      = 1'b0;
      brk_hit = 1'b0;
    end
  end

  // Output register: a new char may replace one accepted in the same cycle.
  always_comb begin
    acc    = vld_q & rx_data_rdy;
    data_d = data_q;
    se_d   = se_q;
    pe_d   = pe_q;
    vld_d  = vld_q & ~acc;
    ovr_d  = 1'b0;
    brk_d  = brk_hit;
    if (ld) begin
      if (!vld_q || acc) begin
        data_d = ld_data;
        se_d   = ld_se;
        pe_d   = par_err_q;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      line_q    <= 1'b1;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      brk_cnt_q <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      se_q      <= 1'b0;
      pe_q      <= 1'b0;
      ovr_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      line_q    <= line_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      par_bit_q <= par_bit_d;
      brk_cnt_q <= brk_cnt_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      se_q      <= se_d;
      pe_q      <= pe_d;
      ovr_q     <= ovr_d;
      brk_q     <= brk_d;
    end
  end

  assign rx_data_vld = vld_q;
  assign rx_data     = data_q;
  assign rx_stop_err = se_q;
  assign rx_par_err  = pe_q;
  assign rx_overrun  = ovr_q;
  assign rx_break    = brk_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lin_rx_os.sv
// tb_lin_rx_os: drives bit-level waveforms into an 8N1 receiver (u0) and an
// 8E1 receiver (u1); expected results come from a frame-level model.
module tb_lin_rx_os;
  localparam int OSR = 16;
  localparam int BREAK_BITS = 11;

  logic clk = 1'b0, rst_n = 1'b1, rx_en = 1'b0;
  logic [15:0] baud_div = 16'd1;
  logic line0 = 1'b1, line1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
  logic vld0, se0, pe0, ovr0, brk0, busy0;
  logic vld1, se1, pe1, ovr1, brk1, busy1;
  logic [7:0] data0, data1;

  always #5 clk = ~clk;

  lin_rx_os #(.DATA_W(8), .OSR(OSR)) u0 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rx_en(rx_en),
    .lin_rx_rtl(line0), .rx_data_vld(vld0), .rx_data_rdy(rdy0),
    .rx_data(data0), .rx_stop_err(se0), .rx_par_err(pe0),
    .rx_overrun(ovr0), .rx_break(brk0), .rx_busy(busy0));

  lin_rx_os #(.DATA_W(8), .OSR(OSR), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .rx_en(rx_en),
    .lin_rx_rtl(line1), .rx_data_vld(vld1), .rx_data_rdy(rdy1),
    .rx_data(data1), .rx_stop_err(se1), .rx_par_err(pe1),
    .rx_overrun(ovr1), .rx_break(brk1), .rx_busy(busy1));

  typedef struct packed {logic [7:0] d; logic se; logic pe;} chr_t;
  typedef struct {bit has_chr; bit brk; chr_t c;} exp_t;

  chr_t got0[$], got1[$];
  int brk_n0 = 0, brk_n1 = 0, ovr_n0 = 0, ovr_n1 = 0;
  int total = 0, bad = 0;

  always @(negedge clk) begin
    if (vld0 && rdy0) got0.push_back(chr_t'({data0, se0, pe0}));
    if (vld1 && rdy1) got1.push_back(chr_t'({data1, se1, pe1}));
    if (brk0) brk_n0++;
    if (brk1) brk_n1++;
    if (ovr0) ovr_n0++;
    if (ovr1) ovr_n1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: what a receiver must report for start, 8 data bits,
  // optional parity bit, stop bit, then extra_low further dominant bits.
  function automatic exp_t model(input logic [7:0] d, input bit has_par,
                                 input bit pb, input bit sb, input int extra_low);
    exp_t e;
    int low;
    e.has_chr = 0; e.brk = 0; e.c = '0;
    if (!sb && d == 8'h00 && !(has_par && pb)) begin
      low = 2 + 8 + (has_par ? 1 : 0) + extra_low;
      if (extra_low > 0 && low >= BREAK_BITS) e.brk = 1;
      else begin e.has_chr = 1; e.c.se = 1'b1; end
    end else begin
      e.has_chr = 1;
      e.c.d  = d;
      e.c.se = !sb;
      e.c.pe = has_par ? ($countones({d, pb}) % 2 == 1) : 1'b0;
    end
    return e;
  endfunction

  task automatic drive(input int inst, input logic lvl, input int cyc);
    if (inst == 0) line0 = lvl; else line1 = lvl;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  function automatic int bit_t();
    return OSR * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  task automatic send(input int inst, input logic [7:0] d, input bit has_par,
                      input bit pb, input bit sb, input int extra_low);
    int bt;
    bt = bit_t();
    drive(inst, 1'b0, bt);
    for (int i = 0; i < 8; i++) drive(inst, d[i], bt);
    if (has_par) drive(inst, pb, bt);
    drive(inst, sb, bt);
    if (extra_low > 0) drive(inst, 1'b0, bt * extra_low);
    drive(inst, 1'b1, 3 * bt);
  endtask

  task automatic check_frame(input string tag, input int inst, input exp_t e);
    chr_t g;
    int n, nb;
    n  = (inst == 0) ? got0.size() : got1.size();
    nb = (inst == 0) ? brk_n0 : brk_n1;
    chk({tag, "_nchr"}, n, e.has_chr ? 1 : 0);
    chk({tag, "_brk"}, nb, e.brk ? 1 : 0);
    chk({tag, "_busy"}, (inst == 0) ? busy0 : busy1, 1'b0);
    if (e.has_chr && n > 0) begin
      g = (inst == 0) ? got0[0] : got1[0];
      chk({tag, "_data"}, g.d, e.c.d);
      chk({tag, "_se"}, g.se, e.c.se);
      chk({tag, "_pe"}, g.pe, e.c.pe);
    end
    got0.delete(); got1.delete();
    brk_n0 = 0; brk_n1 = 0;
  endtask

  initial begin
    exp_t none;
    logic [7:0] d;
    bit sb, pb;
    none.has_chr = 0; none.brk = 0; none.c = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", vld0, 1'b0);
    chk("rst_data", data0, 8'h00);
    chk("rst_se", se0, 1'b0);
    chk("rst_pe", pe0, 1'b0);
    chk("rst_ovr", ovr0, 1'b0);
    chk("rst_brk", brk0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_vld1", vld1, 1'b0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Basic character
    send(0, 8'hA5, 0, 0, 1, 0);
    check_frame("a5", 0, model(8'hA5, 0, 0, 1, 0));

    // Short glitch must be rejected by the start vote
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 3 * bit_t());
    check_frame("glitch", 0, none);

    // Even parity
    send(1, 8'h07, 1, 0, 1, 0);
    check_frame("par0", 1, model(8'h07, 1, 0, 1, 0));
    send(1, 8'h07, 1, 1, 1, 0);
    check_frame("par1", 1, model(8'h07, 1, 1, 1, 0));

    // Framing error, then a quiet line
    send(0, 8'h3C, 0, 0, 0, 0);
    check_frame("stop0", 0, model(8'h3C, 0, 0, 0, 0));
    drive(0, 1'b1, 4 * bit_t());
    check_frame("quiet", 0, none);

    // Break: 13 dominant bits, then 10 dominant bits (too short)
    send(0, 8'h00, 0, 0, 0, 3);
    check_frame("brk13", 0, model(8'h00, 0, 0, 0, 3));
    send(0, 8'h00, 0, 0, 0, 0);
    check_frame("brk10", 0, model(8'h00, 0, 0, 0, 0));

    // Random characters, random bit rate (0 acts as 1)
    for (int i = 0; i < 10; i++) begin
      baud_div = 16'($urandom_range(0, 3));
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send(0, d, 0, 0, sb, 0);
      check_frame("rnd0", 0, model(d, 0, 0, sb, 0));
    end
    for (int i = 0; i < 6; i++) begin
      baud_div = 16'($urandom_range(1, 2));
      d  = 8'($urandom);
      pb = $urandom_range(0, 1);
      send(1, d, 1, pb, 1, 0);
      check_frame("rnd1", 1, model(d, 1, pb, 1, 0));
    end
    baud_div = 16'd1;

    // Disable mid character: discarded silently
    drive(0, 1'b0, bit_t());
    drive(0, 1'b1, 2 * bit_t());
    rx_en = 1'b0;
    drive(0, 1'b0, 3 * bit_t());
    drive(0, 1'b1, 5 * bit_t());
    check_frame("dis_mid", 0, none);
    // Re-enable while the line is low: no start without a fresh edge
    drive(0, 1'b0, bit_t());
    rx_en = 1'b1;
    drive(0, 1'b0, 2 * bit_t());
    drive(0, 1'b1, 12 * bit_t());
    check_frame("reen_low", 0, none);
    chk("ovr_none", ovr_n0, 0);

    // Overrun
    rdy0 = 1'b0;
    send(0, 8'h11, 0, 0, 1, 0);
    send(0, 8'h22, 0, 0, 1, 0);
    chk("ovr_cnt", ovr_n0, 1);
    chk("ovr_vld", vld0, 1'b1);
    chk("ovr_data", data0, 8'h11);
    chk("ovr_nacc", got0.size(), 0);
    rdy0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_drop", vld0, 1'b0);
    chk("ovr_acc", got0.size(), 1);
    if (got0.size() > 0) chk("ovr_accd", got0[0].d, 8'h11);
    chk("ovr_cnt2", ovr_n0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lin_rx_os.md
Name: lin_rx_os

Overview:
Parametrised LIN/UART byte receiver that owns its own bit timing. It samples lin_rx_rtl at OSR ticks per bit and validates start bits. Per bit it decides with a 3-sample majority vote, then checks optional parity and the stop bit. It detects the LIN break field and delivers bytes through a valid/ready handshake with overrun reporting. It sits between the LIN transceiver pin and the frame-level protocol controller.

Parameters:
DATA_W, 8, data bits per character, 5..9, LSB first
OSR, 16, oversample ticks per bit, 8..32, even
PARITY_EN, 0, 1 = one parity bit follows data
PARITY_ODD, 0, 1 = odd parity, 0 = even (only when PARITY_EN=1)
BREAK_BITS, 11, consecutive dominant bit times that constitute a break

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
baud_div  in  16  clk cycles per oversample tick; 0 treated as 1
rx_en  in  1  receiver enable
lin_rx_rtl  in  1  raw LIN RX pin (asynchronous, recessive = 1)
rx_data_vld  out  1  output byte valid, held until accepted
rx_data_rdy  in  1  consumer ready
rx_data  out  DATA_W  received character
rx_stop_err  out  1  stop bit sampled dominant; qualifies rx_data_vld
rx_par_err  out  1  parity mismatch; qualifies rx_data_vld; 0 if PARITY_EN=0
rx_overrun  out  1  1-cycle pulse: completed character dropped because output was full
rx_break  out  1  1-cycle pulse: break field detected
rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0 and rx_data 0; synchroniser and sampled line = 1; FSM IDLE; counters 0.
- Input path: 2-FF synchroniser; edge detect on the synchronised signal only.
- Tick generator: down-counter reloads to max(baud_div,1)-1 and emits tick at 0. It runs freely, but on start detection it reloads and the oversample counter clears, so bit phase aligns to the edge.
- Majority vote: samples at oversample counts OSR/2-1, OSR/2, OSR/2+1 within each bit. The bit decision is taken on the tick of the third sample.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK, WAIT_HIGH.
  - IDLE: rx_en=1 and a 1->0 synchronised edge -> START.
  - START: voted 1 -> IDLE (glitch rejected, nothing reported). Voted 0 -> DATA.
  - DATA: shifts DATA_W bits LSB first. Then -> PARITY if PARITY_EN, else -> STOP.
  - PARITY: computes par_err from data plus the received parity bit -> STOP.
  - STOP, voted 1: deliver the character -> IDLE.
  - STOP, voted 0 with data all zero (and parity bit 0 if enabled): -> BREAK. The dominant bit count so far is 2+DATA_W+PARITY_EN.
  - STOP, voted 0 otherwise: deliver with stop_err=1 -> WAIT_HIGH.
  - BREAK: increments the dominant count each further full bit time the line stays low.
    - Count reaches BREAK_BITS: pulse rx_break once -> WAIT_HIGH. No character is delivered.
    - Line returns high first: deliver an all-zero character with stop_err=1 -> IDLE.
  - WAIT_HIGH: synchronised line = 1 -> IDLE.
- Delivery into the output register:
  - Output empty, or accepted in the same cycle (vld & rdy): load rx_data, rx_stop_err, rx_par_err and set rx_data_vld the clk cycle after the deciding tick.
  - Output full and not being accepted: keep the old contents and pulse rx_overrun.
- Handshake: rx_data_vld clears the cycle after vld & rdy unless a new load occurs in that same cycle. Output fields are stable while vld=1.
- rx_en=0: FSM forced to IDLE next cycle and any partial character is discarded silently. The output register and handshake are unaffected. Re-enable while the line is low does not start reception until a fresh falling edge.
- baud_div change takes effect at the next reload; mid-character changes are not supported.
- Async reset mid-character returns everything to reset values immediately.

Decomposition:
- Shared package lin_pkg: FSM state enum, OSR sample-point constants, parity-mode constants. The same constants serve the future lin_tx successor.
- One sub-module, lin_os_tick: tick generator plus oversample counter, with phase-align input and tick/sample-strobe outputs.
- The synchroniser and vote logic stay inline.

Test Plan:
- Defaults, baud_div=1 (16 clk/bit), rx_data_rdy=1, send 0xA5 with stop=1 -> one rx_data_vld pulse with rx_data=0xA5 and both error flags 0; rx_busy low after STOP.
- 3-clk low glitch on an idle line -> START rejects it; no vld and no error; FSM back in IDLE.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> rx_par_err=1, rx_data=0x07. Repeat with parity 1 -> rx_par_err=0.
- Send 0x3C with stop=0, then line high -> vld with rx_stop_err=1, rx_data=0x3C; no reception until the next falling edge.
- Hold the line low for 13 bit times, then high for 1 bit -> exactly one rx_break pulse when the 11th dominant bit ends; no vld. Low for 10 bits then high -> vld with rx_data=0x00 and rx_stop_err=1, no break.
- rx_data_rdy=0, send 0x11 then 0x22 -> rx_data stays 0x11 and rx_overrun pulses once at the end of 0x22. Raise rdy -> 0x11 accepted and vld drops.
